dac_wave_gen: RTL and testbench

Upstream sample source for the SPI DAC serializer. Generates a periodic waveform (sawtooth, triangle, square or hold) at a programmable sample rate. Formats each 12-bit sample into a 16-bit DAC command word. Hands words downstream over a valid/ready handshake through a 2-entry buffer, so serializer stalls never corrupt sample timing.

---
 rtl/dac_wave_gen.sv | 138 +++++++++++++
 tb/tb_dac_wave_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// dac_wave_gen
//   Periodic waveform source for the SPI DAC serializer. Every CLK_DIV
//   cycles one 12-bit sample (sawtooth / triangle / square / hold) is
//   formatted as {CONFIG, sample} and queued in a 2-entry FIFO. The FIFO
//   feeds the serializer over a valid/ready handshake.
//
// Ports
//   clk     in   system clock, rising edge
//   enable  in   synchronous active-low reset (low = held in reset)
//   mode    in   [1:0]  0 sawtooth, 1 triangle, 2 square, 3 hold
//   step    in   [11:0] phase increment per sample
//   word    out  [15:0] DAC command word at the FIFO head
//   valid   out  FIFO not empty
//   ready   in   downstream accepts word
//   overrun out  sticky: a sample was dropped on a full FIFO
module dac_wave_gen #(
  parameter int          CLK_DIV = 64,
  parameter logic [3:0]  CONFIG  = 4'b0001
) (
  input  logic        clk,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] step,
  output logic [15:0] word,
  output logic        valid,
  input  logic        ready,
  output logic        overrun
);

  localparam logic [15:0] TIMER_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_SAW  = 2'd0,
    MODE_TRI  = 2'd1,
    MODE_SQR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  logic [15:0] timer_q, timer_d;
  logic        tick_q, tick_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] last_q, last_d;
  logic [15:0] mem_q [2];
  logic [15:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        overrun_q, overrun_d;

  logic [11:0] sample;
  logic        pop;
  logic        push_ok;
  logic        wr_ptr;

  // The falling half of the triangle is 4095 - 2*(acc-2048); since
  // 2*(acc-2048) fits in 12 bits, that subtraction is a bitwise invert.
  function automatic logic [11:0] wave_sample(input logic [1:0]  m,
                                              input logic [11:0] a,
                                              input logic [11:0] last);
    logic [11:0] s;
    case (mode_e'(m))
      MODE_SAW: s = a;
      MODE_TRI: s = a[11] ? ~{a[10:0], 1'b0} : {a[10:0], 1'b0};
      MODE_SQR: s = {12{a[11]}};
      default:  s = last;
    endcase
    return s;
  endfunction

  assign valid   = (count_q != 2'd0);
  assign word    = mem_q[rd_ptr_q];
  assign overrun = overrun_q;

  always_comb begin
    timer_d   = timer_q - 16'd1;
    tick_d    = 1'b0;
    acc_d     = acc_q;
    last_d    = last_q;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    // The tick is registered, so the sample is taken one cycle after the
    // timer hits zero; this puts the first word CLK_DIV+1 cycles after
    // release while keeping the CLK_DIV spacing between words.
    if (timer_q == 16'd0) begin
      timer_d = TIMER_RELOAD;
      tick_d  = 1'b1;
    end

    sample  = wave_sample(mode, acc_q, last_q);
    pop     = valid && ready;
    // A pop on a full FIFO frees the head slot in the same edge.
    push_ok = tick_q && ((count_q != 2'd2) || pop);
    // Tail slot: head when empty, other slot with one entry, and the
    // slot being popped when full.
    wr_ptr  = rd_ptr_q ^ (count_q == 2'd1);

    if (tick_q) begin
      last_d = sample;
      if (mode_e'(mode) != MODE_HOLD) acc_d = acc_q + step;
      if (!push_ok) overrun_d = 1'b1;
    end

    if (push_ok) mem_d[wr_ptr] = {CONFIG, sample};
    if (pop)     rd_ptr_d = ~rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!enable) begin
      timer_q   <= TIMER_RELOAD;
      tick_q    <= 1'b0;
      acc_q     <= 12'd0;
      last_q    <= 12'd0;
      mem_q[0]  <= 16'd0;
      mem_q[1]  <= 16'd0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      tick_q    <= tick_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen
//   Bench for dac_wave_gen with CLK_DIV=8. A queue-based model predicts
//   valid/word/overrun each cycle from the sample schedule; directed
//   sequences pin delivered words, first-word latency and overrun.
module tb_dac_wave_gen;

  localparam int         CLK_DIV = 8;
  localparam logic [3:0] CONFIG  = 4'b0001;

  logic        clk    = 1'b0;
  logic        enable = 1'b0;
  logic        ready  = 1'b0;
  logic [1:0]  mode   = 2'd0;
  logic [11:0] step   = 12'd0;
  logic [15:0] word;
  logic        valid;
  logic        overrun;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] dut_words[$];
  logic [15:0] exp_q[$];

  // model state
  int          m_edges = 0;
  int          m_acc   = 0;
  int          m_last  = 0;
  logic        m_ovr   = 1'b0;
  logic        m_rst   = 1'b1;
  logic [15:0] m_q[$];
  int          m_s;
  logic [15:0] m_dummy;

  dac_wave_gen #(.CLK_DIV(CLK_DIV), .CONFIG(CONFIG)) dut (
    .clk     (clk),
    .enable  (enable),
    .mode    (mode),
    .step    (step),
    .word    (word),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  function automatic int wave(input int md, input int a, input int last);
    case (md)
      0:       return a;
      1:       return (a < 2048) ? 2 * a : 4095 - 2 * (a - 2048);
      2:       return (a >= 2048) ? 4095 : 0;
      default: return last;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model and per-cycle compare: update at each rising edge from the
  // inputs seen there, compare on the following falling edge.
  initial forever begin
    @(posedge clk);
    if (!enable) begin
      m_rst = 1'b1; m_edges = 0; m_acc = 0; m_last = 0; m_ovr = 1'b0;
      m_q.delete();
    end else begin
      m_rst = 1'b0;
      m_edges++;
      if (m_q.size() > 0 && ready) m_dummy = m_q.pop_front();
      if (m_edges > CLK_DIV && (m_edges - 1) % CLK_DIV == 0) begin
        m_s    = wave(int'(mode), m_acc, m_last);
        m_last = m_s;
        if (mode != 2'd3) m_acc = (m_acc + int'(step)) % 4096;
        if (m_q.size() < 2) m_q.push_back({CONFIG, 12'(m_s)});
        else m_ovr = 1'b1;
      end
    end
    @(negedge clk);
    check("cyc_valid", 32'(valid), 32'(m_q.size() != 0));
    check("cyc_overrun", 32'(overrun), 32'(m_ovr));
    if (m_q.size() != 0) check("cyc_word", 32'(word), 32'(m_q[0]));
    if (m_rst) check("cyc_reset_word", 32'(word), 32'h0);
    if (valid && ready) dut_words.push_back(word);
  end

  task automatic tick_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    tick_edges(2);
    dut_words.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (dut_words.size() < n && k < budget) begin
      tick_edges(1);
      k++;
    end
    if (dut_words.size() < n) begin
      chk_cnt++;
      $display("FAIL %s_timeout: got %0d words, expected %0d", name, dut_words.size(), n);
    end
  endtask

  task automatic check_words(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dut_words.size()) check(name, 32'(dut_words[i]), 32'(exp_q[i]));
      else begin
        chk_cnt++;
        $display("FAIL %s: word %0d missing, expected 0x%0h", name, i, exp_q[i]);
      end
    end
  endtask

  // Called right after enable is raised (posedge + 1).
  task automatic measure_rise(input string name);
    int k = 0;
    while (k < 20) begin
      tick_edges(1);
      k++;
      if (valid) break;
    end
    check({name, "_latency"}, 32'(k), 32'(CLK_DIV + 1));
    check({name, "_first_word"}, 32'(word), 32'h1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcnt;

    // Sawtooth step 16, latency and spacing
    mode = 2'd0; step = 12'd16; ready = 1'b1; enable = 1'b0;
    tick_edges(3);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_word", 32'(word), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    enable = 1'b1;
    measure_rise("saw");
    wait_words(4, 40, "saw");
    exp_q = '{16'h1000, 16'h1010, 16'h1020, 16'h1030};
    check_words("saw_words");
    vcnt = 0;
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      tick_edges(1);
      if (valid) vcnt++;
    end
    check("saw_valid_duty", 32'(vcnt), 32'd2);

    // Triangle step 1024
    do_reset();
    mode = 2'd1; step = 12'd1024; ready = 1'b1;
    enable = 1'b1;
    wait_words(6, 80, "tri");
    exp_q = '{16'h1000, 16'h1800, 16'h1FFF, 16'h17FF, 16'h1000, 16'h1800};
    check_words("tri_words");

    // Square step 2048, then hold, then square again
    do_reset();
    mode = 2'd2; step = 12'd2048; ready = 1'b1;
    enable = 1'b1;
    wait_words(3, 60, "sqr");
    mode = 2'd3;
    wait_words(6, 60, "hold");
    mode = 2'd2;
    wait_words(8, 40, "sqr2");
    exp_q = '{16'h1000, 16'h1FFF, 16'h1000, 16'h1000, 16'h1000, 16'h1000,
              16'h1FFF, 16'h1000};
    check_words("sqr_hold_words");

    // Overrun on third tick with ready low
    do_reset();
    mode = 2'd0; step = 12'd16; ready = 1'b0;
    enable = 1'b1;
    tick_edges(3 * CLK_DIV);
    check("ovr_before_third", 32'(overrun), 32'h0);
    tick_edges(1);
    check("ovr_after_third", 32'(overrun), 32'h1);
    ready = 1'b1;
    wait_words(3, 40, "ovr");
    exp_q = '{16'h1000, 16'h1010, 16'h1030};
    check_words("ovr_words");
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Full FIFO, ready high exactly on the push edge
    do_reset();
    mode = 2'd0; step = 12'd16; ready = 1'b0;
    enable = 1'b1;
    tick_edges(3 * CLK_DIV);
    ready = 1'b1;
    tick_edges(1);
    ready = 1'b0;
    check("full_pushpop_overrun", 32'(overrun), 32'h0);
    check("full_pushpop_head", 32'(word), 32'h1010);
    ready = 1'b1;
    wait_words(3, 40, "full");
    exp_q = '{16'h1000, 16'h1010, 16'h1020};
    check_words("full_words");
    check("full_overrun_final", 32'(overrun), 32'h0);

    // Wrap with step 0xFF0, then reset mid-transfer
    do_reset();
    mode = 2'd0; step = 12'hFF0; ready = 1'b1;
    enable = 1'b1;
    wait_words(3, 60, "wrap");
    exp_q = '{16'h1000, 16'h1FF0, 16'h1FE0};
    check_words("wrap_words");
    ready = 1'b0;
    vcnt = 0;
    while (!valid && vcnt < 20) begin
      tick_edges(1);
      vcnt++;
    end
    check("wrap_pending_valid", 32'(valid), 32'h1);
    enable = 1'b0;
    tick_edges(1);
    check("rst_mid_valid", 32'(valid), 32'h0);
    check("rst_mid_overrun", 32'(overrun), 32'h0);
    check("rst_mid_word", 32'(word), 32'h0);
    enable = 1'b1;
    measure_rise("rerelease");

    tick_edges(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
